// File: rtl/mc_seq_pkg.sv
// Shared state encoding, instruction field constants and control-word layout for the
// multi-cycle MIPS sequencer.
package mc_seq_pkg;

  localparam int unsigned StateW = 4;

  // Encodings 14 and 15 are unused and recover to StFetch.
  typedef enum logic [StateW-1:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StRwb    = 4'd7,
    StExecI  = 4'd8,
    StIwb    = 4'd9,
    StBranch = 4'd10,
    StJump   = 4'd11,
    StJal    = 4'd12,
    StHalt   = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype   = 6'b000000;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpSw      = 6'b101011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpAddi    = 6'b001000;
  localparam logic [5:0] OpAndi    = 6'b001100;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpLui     = 6'b001111;
  localparam logic [5:0] FnSyscall = 6'b001100;

  localparam logic [1:0] AluAdd    = 2'd0;
  localparam logic [1:0] AluSub    = 2'd1;
  localparam logic [1:0] AluFunct  = 2'd2;
  localparam logic [1:0] AluOpcode = 2'd3;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  localparam logic [1:0] WbAluOut = 2'd0;
  localparam logic [1:0] WbMdr    = 2'd1;
  localparam logic [1:0] WbPc     = 2'd2;

  localparam logic       SrcAPc   = 1'b0;
  localparam logic       SrcABusA = 1'b1;
  localparam logic [1:0] SrcBBusB = 2'd0;
  localparam logic [1:0] SrcBOne  = 2'd1;
  localparam logic [1:0] SrcBImm  = 2'd2;
  localparam logic [1:0] SrcBBr   = 2'd3;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       i_or_d;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

  // Everything deasserted; each state only sets the fields it owns.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/mc_seq_decode.sv
// Combinational decode: current state plus IR fields to next state, control word,
// illegal-opcode flag and instruction-completion flag.
module mc_seq_decode
  import mc_seq_pkg::*;
#(
  parameter int unsigned OPW = 6
) (
  input  state_e         state,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           mem_ready,
  output state_e         state_next,
  output ctrl_t          ctrl,
  output logic           illegal,
  output logic           done
);

  always_comb begin
    state_next = StFetch;
    ctrl       = ctrl_idle();
    illegal    = 1'b0;
    done       = 1'b0;

    case (state)
      StFetch: begin
        ctrl.mem_rd    = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = SrcAPc;
        ctrl.alu_src_b = SrcBOne;
        ctrl.alu_op    = AluAdd;
        ctrl.pc_src    = PcSrcAlu;
        // IR load and PC+1 both commit on the cycle the memory returns the word.
        ctrl.pc_wr     = mem_ready;
        ctrl.ir_wr     = mem_ready;
        state_next     = mem_ready ? StDecode : StFetch;
      end

      StDecode: begin
        ctrl.alu_src_a = SrcAPc;
        ctrl.alu_src_b = SrcBBr;
        case (opcode)
          OPW'(OpRtype): state_next = (funct == OPW'(FnSyscall)) ? StHalt : StExecR;
          OPW'(OpLw),
          OPW'(OpSw):    state_next = StMemAdr;
          OPW'(OpBeq):   state_next = StBranch;
          OPW'(OpJ):     state_next = StJump;
          OPW'(OpJal):   state_next = StJal;
          OPW'(OpAddi),
          OPW'(OpAndi),
          OPW'(OpOri),
          OPW'(OpLui):   state_next = StExecI;
          default: begin
            state_next = StFetch;
            illegal    = 1'b1;
          end
        endcase
      end

      StExecR: begin
        ctrl.alu_src_a = SrcABusA;
        ctrl.alu_src_b = SrcBBusB;
        ctrl.alu_op    = AluFunct;
        state_next     = StRwb;
      end

      StRwb: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = RegDstRd;
        ctrl.mem_to_reg = WbAluOut;
        done            = 1'b1;
      end

      StExecI: begin
        ctrl.alu_src_a = SrcABusA;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluOpcode;
        state_next     = StIwb;
      end

      StIwb: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = RegDstRt;
        ctrl.mem_to_reg = WbAluOut;
        done            = 1'b1;
      end

      StMemAdr: begin
        ctrl.alu_src_a = SrcABusA;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluAdd;
        state_next     = (opcode == OPW'(OpSw)) ? StMemWr : StMemRd;
      end

      StMemRd: begin
        ctrl.i_or_d = 1'b1;
        ctrl.mem_rd = 1'b1;
        state_next  = mem_ready ? StMemWb : StMemRd;
      end

      StMemWb: begin
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = RegDstRt;
        ctrl.mem_to_reg = WbMdr;
        done            = 1'b1;
      end

      StMemWr: begin
        ctrl.i_or_d = 1'b1;
        ctrl.mem_wr = 1'b1;
        state_next  = mem_ready ? StFetch : StMemWr;
        done        = mem_ready;
      end

      StBranch: begin
        ctrl.alu_src_a  = SrcABusA;
        ctrl.alu_src_b  = SrcBBusB;
        ctrl.alu_op     = AluSub;
        ctrl.pc_wr_cond = 1'b1;
        ctrl.pc_src     = PcSrcAluOut;
        done            = 1'b1;
      end

      StJump: begin
        ctrl.pc_wr  = 1'b1;
        ctrl.pc_src = PcSrcJump;
        done        = 1'b1;
      end

      StJal: begin
        // Regfile captures the old PC on this edge while the PC takes the target.
        ctrl.reg_wr     = 1'b1;
        ctrl.reg_dst    = RegDstRa;
        ctrl.mem_to_reg = WbPc;
        ctrl.pc_wr      = 1'b1;
        ctrl.pc_src     = PcSrcJump;
        done            = 1'b1;
      end

      StHalt: begin
        ctrl.halted = 1'b1;
        state_next  = StHalt;
      end

      default: state_next = StFetch;
    endcase
  end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle MIPS control sequencer: state register, output drive and illegal pulse.
// Define MC_SEQ_PERF_EN to add the cyc_cnt / instr_cnt performance counters.
module mc_seq_ctrl
  import mc_seq_pkg::*;
#(
  parameter int unsigned OPW  = 6,
  parameter int unsigned STW  = 4,
  parameter int unsigned CNTW = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  funct,
  input  logic            Zero,
  input  logic            mem_ready,
  output logic            PCWr,
  output logic            PCWrCond,
  output logic            IorD,
  output logic            MemRd,
  output logic            MemWr,
  output logic            IRWr,
  output logic            RegWr,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemtoReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSrc,
  output logic [STW-1:0]  state,
  output logic            halted,
  output logic            illegal
`ifdef MC_SEQ_PERF_EN
  ,
  output logic [CNTW-1:0] cyc_cnt,
  output logic [CNTW-1:0] instr_cnt
`endif
);

  state_e state_q, state_d, state_cur;
  ctrl_t  ctrl;
  logic   dec_illegal;
  logic   done;

  // Zero is combined with PCWrCond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = Zero;

  // While Reset is held the outputs already show the FETCH control word.
  always_comb begin
    state_cur = Reset ? state_q : StFetch;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  mc_seq_decode #(
    .OPW (OPW)
  ) u_decode (
    .state      (state_cur),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .state_next (state_d),
    .ctrl       (ctrl),
    .illegal    (dec_illegal),
    .done       (done)
  );

  always_comb begin
    PCWr     = ctrl.pc_wr;
    PCWrCond = ctrl.pc_wr_cond;
    IorD     = ctrl.i_or_d;
    MemRd    = ctrl.mem_rd;
    MemWr    = ctrl.mem_wr;
    IRWr     = ctrl.ir_wr;
    RegWr    = ctrl.reg_wr;
    RegDst   = ctrl.reg_dst;
    MemtoReg = ctrl.mem_to_reg;
    ALUSrcA  = ctrl.alu_src_a;
    ALUSrcB  = ctrl.alu_src_b;
    ALUOp    = ctrl.alu_op;
    PCSrc    = ctrl.pc_src;
    halted   = ctrl.halted;
    illegal  = dec_illegal;
    state    = STW'(state_cur);
  end

`ifdef MC_SEQ_PERF_EN
  logic [CNTW-1:0] cyc_q, instr_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      if (!ctrl.halted) begin
        cyc_q <= cyc_q + CNTW'(1);
      end
      if (done) begin
        instr_q <= instr_q + CNTW'(1);
      end
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule
